// File: rtl/radix2_sdf_stage_8.sv
// Radix-2 SDF butterfly stage: 8-deep complex feedback delay line plus twiddle multiplier.
// Optional macro SDF_ROUND_EN: round-half-up on the twiddle product before the FRAC shift.
module radix2_sdf_stage_8 #(
    parameter int WIDTH = 24,
    parameter int DELAY = 8,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        din_r,
    input  logic [WIDTH-1:0]        din_i,
    input  logic [1:0]              state,
    input  logic [WIDTH-1:0]        w_r,
    input  logic [WIDTH-1:0]        w_i,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        dout_r,
    output logic [WIDTH-1:0]        dout_i
);

`ifdef SDF_ROUND_EN
    localparam int RND = 1 << (FRAC - 1);
`else
    localparam int RND = 0;
`endif

    logic [WIDTH-1:0] dl_r_q [DELAY];
    logic [WIDTH-1:0] dl_i_q [DELAY];
    logic [WIDTH-1:0] dout_r_q, dout_i_q, dout_r_d, dout_i_d;
    logic             vld_q, vld_d;
    logic             adv;
    logic [WIDTH-1:0] push_r, push_i, smp_r, smp_i, head_r, head_i;

    logic signed [2*WIDTH-1:0] hr_x, hi_x, wr_x, wi_x, re_full, im_full;
    logic                      unused_bits;

    assign head_r = dl_r_q[0];
    assign head_i = dl_i_q[0];

    // Full 2*WIDTH precision so the products never overflow before the shift.
    assign hr_x    = {{WIDTH{head_r[WIDTH-1]}}, head_r};
    assign hi_x    = {{WIDTH{head_i[WIDTH-1]}}, head_i};
    assign wr_x    = {{WIDTH{w_r[WIDTH-1]}}, w_r};
    assign wi_x    = {{WIDTH{w_i[WIDTH-1]}}, w_i};
    assign re_full = hr_x * wr_x - hi_x * wi_x + (2*WIDTH)'(RND);
    assign im_full = hr_x * wi_x + hi_x * wr_x + (2*WIDTH)'(RND);

    // Arithmetic shift by FRAC then truncate == take this bit window.
    assign unused_bits = ^{re_full[2*WIDTH-1:FRAC+WIDTH], re_full[FRAC-1:0],
                           im_full[2*WIDTH-1:FRAC+WIDTH], im_full[FRAC-1:0]};

    always_comb begin
        smp_r    = in_valid ? din_r : '0;
        smp_i    = in_valid ? din_i : '0;
        adv      = in_valid;
        push_r   = din_r;
        push_i   = din_i;
        dout_r_d = dout_r_q;
        dout_i_d = dout_i_q;
        vld_d    = 1'b0;
        case (state)
            2'd1: begin
                adv      = 1'b1;
                push_r   = head_r - smp_r;
                push_i   = head_i - smp_i;
                dout_r_d = head_r + smp_r;
                dout_i_d = head_i + smp_i;
                vld_d    = 1'b1;
            end
            2'd2: begin
                adv      = 1'b1;
                push_r   = smp_r;
                push_i   = smp_i;
                dout_r_d = re_full[FRAC +: WIDTH];
                dout_i_d = im_full[FRAC +: WIDTH];
                vld_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                dl_r_q[i] <= '0;
                dl_i_q[i] <= '0;
            end
            dout_r_q <= '0;
            dout_i_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            if (adv) begin
                for (int i = 0; i < DELAY - 1; i++) begin
                    dl_r_q[i] <= dl_r_q[i+1];
                    dl_i_q[i] <= dl_i_q[i+1];
                end
                dl_r_q[DELAY-1] <= push_r;
                dl_i_q[DELAY-1] <= push_i;
            end
            dout_r_q <= dout_r_d;
            dout_i_q <= dout_i_d;
            vld_q    <= vld_d;
        end
    end

    assign out_valid = vld_q;
    assign dout_r    = dout_r_q;
    assign dout_i    = dout_i_q;

endmodule

// File: tb/tb_radix2_sdf_stage_8.sv
// Self-checking bench for radix2_sdf_stage_8: directed spec scenarios plus a randomized
// run against a queue-based frame model.
module tb_radix2_sdf_stage_8;
    localparam int W = 24;
    localparam int D = 8;
    localparam int F = 8;
`ifdef SDF_ROUND_EN
    localparam longint RND = 128;
`else
    localparam longint RND = 0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
    logic [1:0]          state = 2'd0;
    logic                out_valid;
    logic signed [W-1:0] dout_r, dout_i;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic signed [W-1:0] mq_r[$], mq_i[$];
    logic                exp_v = 1'b0;
    logic signed [W-1:0] exp_r = '0, exp_i = '0;

    radix2_sdf_stage_8 #(.WIDTH(W), .DELAY(D), .FRAC(F)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
        .state(state), .w_r(w_r), .w_i(w_i), .out_valid(out_valid),
        .dout_r(dout_r), .dout_i(dout_i)
    );

    always #5 clk = ~clk;

    function automatic logic signed [W-1:0] scale(input longint v);
        longint s;
        s = (v + RND) >>> F;
        return s[W-1:0];
    endfunction

    task automatic model_reset();
        mq_r.delete(); mq_i.delete();
        for (int i = 0; i < D; i++) begin mq_r.push_back('0); mq_i.push_back('0); end
        exp_v = 1'b0; exp_r = '0; exp_i = '0;
    endtask

    task automatic model_push(input logic signed [W-1:0] r, input logic signed [W-1:0] i);
        void'(mq_r.pop_front()); void'(mq_i.pop_front());
        mq_r.push_back(r); mq_i.push_back(i);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return #1 after the edge.
    task automatic step(input logic r, input logic v, input logic [1:0] st,
                        input logic signed [W-1:0] dr, input logic signed [W-1:0] di,
                        input logic signed [W-1:0] wr, input logic signed [W-1:0] wi);
        logic signed [W-1:0] sr, si, hr, hi;
        rst = r; in_valid = v; state = st; din_r = dr; din_i = di; w_r = wr; w_i = wi;
        @(posedge clk);
        sr = v ? dr : '0; si = v ? di : '0;
        hr = mq_r[0]; hi = mq_i[0];
        if (r) model_reset();
        else if (st == 2'd1) begin
            exp_v = 1'b1; exp_r = hr + sr; exp_i = hi + si;
            model_push(hr - sr, hi - si);
        end else if (st == 2'd2) begin
            exp_v = 1'b1;
            exp_r = scale(longint'(hr) * longint'(wr) - longint'(hi) * longint'(wi));
            exp_i = scale(longint'(hr) * longint'(wi) + longint'(hi) * longint'(wr));
            model_push(sr, si);
        end else begin
            exp_v = 1'b0;
            if (v) model_push(dr, di);
        end
        #1;
    endtask

    task automatic fill_100();
        for (int k = 0; k < D; k++) begin
            step(1'b0, 1'b1, 2'd0, W'(100 + k), '0, W'($urandom), W'($urandom));
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL fill_valid k=%0d got=%b want=0", k, out_valid);
            end
        end
    endtask

    task automatic butterfly_10();
        for (int k = 0; k < D; k++) begin
            step(1'b0, 1'b1, 2'd1, W'(10), '0, '0, '0);
            checks++;
            if (out_valid !== 1'b1 || dout_r !== W'(110 + k) || dout_i !== '0) begin
                failures++;
                $display("FAIL butterfly k=%0d got v=%b (%0d,%0d) want v=1 (%0d,0)",
                         k, out_valid, dout_r, dout_i, 110 + k);
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'($urandom), 2'($urandom), W'($urandom), W'($urandom),
                 W'($urandom), W'($urandom));
            checks++;
            if (out_valid !== 1'b0 || dout_r !== '0 || dout_i !== '0) begin
                failures++;
                $display("FAIL reset k=%0d got v=%b (%0d,%0d) want v=0 (0,0)", k, out_valid, dout_r, dout_i);
            end
        end
        step(1'b0, 1'b0, 2'd0, W'(55), W'(66), '0, '0);
        checks++;
        if (out_valid !== 1'b0 || dout_r !== '0 || dout_i !== '0) begin
            failures++;
            $display("FAIL reset_release got v=%b (%0d,%0d) want v=0 (0,0)", out_valid, dout_r, dout_i);
        end
    endtask

    task automatic test_fill_butterfly();
        step(1'b1, 1'b0, 2'd0, '0, '0, '0, '0);
        fill_100();
        butterfly_10();
    endtask

    task automatic test_twiddle();
        logic signed [W-1:0] wr_t[D], wi_t[D], er[D], ei[D];
        for (int k = 0; k < D; k++) begin
            wr_t[k] = W'(256); wi_t[k] = '0; er[k] = W'(90 + k); ei[k] = '0;
        end
        wr_t[1] = W'(237); wi_t[1] = -W'(98);  er[1] = W'(84); ei[1] = -W'(35);
        wr_t[3] = W'(98);  wi_t[3] = -W'(237);
`ifdef SDF_ROUND_EN
        er[3] = W'(36); ei[3] = -W'(86);
`else
        er[3] = W'(35); ei[3] = -W'(87);
`endif
        wr_t[4] = '0;      wi_t[4] = -W'(256); er[4] = '0;    ei[4] = -W'(94);
        for (int k = 0; k < D; k++) begin
            step(1'b0, 1'b1, 2'd2, W'($urandom), W'($urandom), wr_t[k], wi_t[k]);
            checks++;
            if (out_valid !== 1'b1 || dout_r !== er[k] || dout_i !== ei[k]) begin
                failures++;
                $display("FAIL twiddle k=%0d got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                         k, out_valid, dout_r, dout_i, er[k], ei[k]);
            end
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b0, 2'd0, '0, '0, '0, '0);
        for (int k = 0; k < D; k++)
            step(1'b0, 1'b1, 2'd0, (k == 0) ? W'(8388607) : '0, '0, '0, '0);
        step(1'b0, 1'b1, 2'd1, W'(1), '0, '0, '0);
        checks++;
        if (dout_r !== -W'(8388608)) begin
            failures++; $display("FAIL wrap_sum got=%0d want=-8388608", dout_r);
        end
        for (int k = 1; k < D; k++) step(1'b0, 1'b1, 2'd1, '0, '0, '0, '0);
        step(1'b0, 1'b1, 2'd2, '0, '0, W'(256), '0);
        checks++;
        if (dout_r !== W'(8388606) || dout_i !== '0) begin
            failures++; $display("FAIL wrap_diff got=(%0d,%0d) want=(8388606,0)", dout_r, dout_i);
        end
    endtask

    task automatic test_midframe_reset();
        step(1'b1, 1'b0, 2'd0, '0, '0, '0, '0);
        fill_100();
        butterfly_10();
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b1, 2'd2, W'($urandom), W'($urandom), W'(256), '0);
        step(1'b1, 1'b1, 2'd2, W'($urandom), W'($urandom), W'(256), '0);
        checks++;
        if (out_valid !== 1'b0 || dout_r !== '0 || dout_i !== '0) begin
            failures++;
            $display("FAIL midreset got v=%b (%0d,%0d) want v=0 (0,0)", out_valid, dout_r, dout_i);
        end
        fill_100();
        butterfly_10();
    endtask

    task automatic test_random();
        logic [1:0] st;
        step(1'b1, 1'b0, 2'd0, '0, '0, '0, '0);
        for (int n = 0; n < 600; n++) begin
            // Mostly a proper frame cadence, occasionally arbitrary states / bubbles / resets.
            st = ((n / D) == 0) ? 2'd0 : (((n / D) % 2 == 1) ? 2'd1 : 2'd2);
            if ($urandom_range(0, 9) == 0) st = 2'($urandom);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) != 0), st,
                 W'($urandom), W'($urandom),
                 ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($signed($urandom_range(0, 512)) - 256),
                 ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($signed($urandom_range(0, 512)) - 256));
            checks++;
            if (out_valid !== exp_v || dout_r !== exp_r || dout_i !== exp_i) begin
                failures++;
                $display("FAIL random n=%0d got v=%b (%0d,%0d) want v=%b (%0d,%0d)",
                         n, out_valid, dout_r, dout_i, exp_v, exp_r, exp_i);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_butterfly();
        test_twiddle();
        test_wrap();
        test_midframe_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/radix2_sdf_stage_8.md
# radix2_sdf_stage_8

Radix-2 single-path delay-feedback (SDF) butterfly stage with an 8-deep feedback delay line and a twiddle multiplier. It is the last 16-point-span stage of the 512-point FFT datapath. It sits directly downstream of the 8-entry twiddle ROM stage and consumes that stage's `state`, `w_r` and `w_i` outputs together with the complex sample stream. Each frame produces sum outputs and then twiddle-weighted difference outputs.

## Interface
- `WIDTH`, 24: signed two's-complement width of samples and twiddles.
- `DELAY`, 8: feedback delay-line depth; equals half the butterfly span.
- `FRAC`, 8: twiddle fractional bits (256 = 1.0).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `din_*` carries a sample this cycle.
- `din_r`, `din_i`  in  WIDTH  complex input sample.
- `state`  in  2  phase from twiddle ROM: 0 fill, 1 butterfly, 2 twiddle-out, 3 treated as 0.
- `w_r`, `w_i`  in  WIDTH  twiddle presented in the same cycle as `state`.
- `out_valid`  out  1  `dout_*` valid.
- `dout_r`, `dout_i`  out  WIDTH  complex output sample.

## Operation
- Delay line: `DELAY` complex entries as a shift register. `head` is the oldest entry. A push appends at the tail and drops `head`.
- Advance rule:
  - In state 0, the line advances only when `in_valid`=1.
  - In states 1 and 2, it advances every cycle. A sample with `in_valid`=0 is taken as 0+j0.
- State 0 (fill): push `din`; `out_valid`=0.
- State 1 (butterfly):
  - `dout` = `head` + `din`.
  - Push `head` − `din`.
- State 2 (twiddle-out):
  - `dout` = `head` × (`w_r` + j`w_i`).
  - Push `din`, which is the first half of the next frame.
- Steady stream: 8 cycles of fill, then alternating 8 cycles of state 1 and 8 cycles of state 2. The state 2 window doubles as the fill for the next frame.
- Add/sub arithmetic: WIDTH-bit two's complement with wrap-around. There is no growth and no saturation.
- Complex multiply:
  - re = `hr`·`w_r` − `hi`·`w_i`; im = `hr`·`w_i` + `hi`·`w_r`.
  - Products and sums are computed at 2·WIDTH bits.
  - The result is arithmetic-shifted right by FRAC (floor), then truncated to the low WIDTH bits.
- `state`, `w_*` and `din` are sampled in the same cycle. The block never reorders or delays twiddles relative to `state`.

## Timing
- Reset: all delay entries 0+j0, `dout_r`=`dout_i`=0, `out_valid`=0.
- Latency: outputs are registered. An input in cycle t gives `dout`/`out_valid` at t+1, for both state 1 and state 2.
- `out_valid` at t+1 equals (`state` at t ∈ {1,2}). In state 0 and state 3, `dout` holds its previous value.
- A state transition 1→2 or 2→1 takes effect on the first cycle of the new state, with no bubble.
- Reset mid-frame:
  - All entries clear and the next non-reset cycle starts in whatever `state` is presented.
  - The twiddle ROM shares `rst` and returns to fill, so both blocks realign.
- Reset has priority over every other event in the same cycle.

## Configuration
- `SDF_ROUND_EN`:
  - Defined: add 2^(FRAC−1) to each 2·WIDTH-bit product sum before the right shift (round half up).
  - Undefined: plain floor truncation.
  - Affects state 2 outputs only.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with arbitrary inputs → `out_valid`=0 and `dout`=0+j0 throughout and one cycle after release.
- Fill then butterfly:
  - Stimulus: state 0 with `din_r`=100..107, `din_i`=0, `in_valid`=1; then state 1 with `din_r`=10 for 8 cycles.
  - Response: `out_valid`=0 during fill; `dout_r`=110..117, `dout_i`=0 on the 8 cycles one cycle later.
- Twiddle-out, exact values (state 2 following the above):
  - Delayed diffs are 90..97.
  - W=(256,0) → dout=(90,0).
  - W=(237,−98) on diff 91 → (84,−35).
  - W=(0,−256) on diff 94 → (0,−94).
- Rounding, diff 93 with W=(98,−237):
  - Without `SDF_ROUND_EN` → (35,−87).
  - With `SDF_ROUND_EN` → (36,−86).
- Wrap: `head_r`=8388607, `din_r`=1 in state 1 → `dout_r`=−8388608; the pushed diff is 8388606.
- Mid-frame reset: assert `rst` for 1 cycle during the 4th state 2 cycle → next outputs are 0+j0. A fresh 8-sample fill then reproduces the second scenario exactly.
